// File: rtl/recv_id_pkg.sv
// Shared definitions for the ID receive path: expected ID bytes, FSM encoding,
// default register addresses, idle-timeout constant and status-word bit positions.
package recv_id_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    // ASCII "2023211013", first character in the most significant byte.
    localparam int                    EXP_ID_LEN = 10;
    localparam logic [8*EXP_ID_LEN-1:0] EXP_ID   = 80'h32_30_32_33_32_31_31_30_31_33;

    localparam logic [31:0] DATA_ADDR_DEF = 32'h3000_0010;
    localparam logic [31:0] STAT_ADDR_DEF = 32'h3000_0014;

    localparam logic [23:0] TIMEOUT_CYC = 24'd1_000_000;

    localparam int STAT_NEMPTY = 0;
    localparam int STAT_FULL   = 1;
    localparam int STAT_DONE   = 2;
    localparam int STAT_MATCH  = 3;
    localparam int STAT_ERR    = 4;
    localparam int STAT_TMO    = 5;

    function automatic logic [7:0] exp_byte(input int idx);
        logic [7:0] b;
        b = 8'h00;
        if (idx >= 0 && idx < EXP_ID_LEN)
            b = EXP_ID[8*(EXP_ID_LEN-1-idx) +: 8];
        return b;
    endfunction

endpackage

// File: rtl/rx_fifo.sv
// Synchronous byte FIFO with flush; combinational head, push/pop/count update at the edge.
// No internal backpressure: the owner pushes when full only together with a pop; flush wins over both.
module rx_fifo #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_flush,
    input  logic          i_push,
    input  logic [7:0]    i_dat,
    input  logic          i_pop,
    output logic [7:0]    o_head,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign w_push = i_push && !i_flush;
    assign w_pop  = i_pop && !i_flush && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= i_dat;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (w_pop && !w_push)
                r_count <= r_count - 1'b1;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/recv_id.sv
// ID receive path: buffers UART RX bytes, matches them against the student ID, status registered (1 cycle), rdata_o combinational.
// A strobe into a full FIFO with no same-cycle pop is dropped and raises ERR; optional RECV_TIMEOUT_EN adds an idle timeout in RECV.
module recv_id
    import recv_id_pkg::*;
#(
    parameter int          FIFO_DEPTH = 16,
    parameter int          ID_LEN     = 10,
    parameter logic [31:0] DATA_ADDR  = DATA_ADDR_DEF,
    parameter logic [31:0] STAT_ADDR  = STAT_ADDR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        recv_start_i,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_err_i,
    input  logic        ex_mem_req_i,
    input  logic        ex_mem_we_i,
    input  logic [31:0] ex_mem_raddr_i,
    output logic [31:0] rdata_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        match_o,
    output logic        err_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int IW = $clog2(ID_LEN + 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [IW-1:0] r_idx;
    logic [IW-1:0] w_idx_nxt;
    logic          r_mflag;
    logic          w_mflag_nxt;
    logic          r_busy;
    logic          r_done;
    logic          r_match;
    logic          r_err;
    logic          w_push;
    logic          w_flush;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [7:0]    w_head;
    logic [CW-1:0] w_count;
    logic          w_ld;
    logic          w_ld_data;
    logic          w_ld_stat;
    logic [31:0]   w_stat;
    logic          w_tmo_flag;

    assign w_ld      = ex_mem_req_i && !ex_mem_we_i;
    assign w_ld_data = w_ld && (ex_mem_raddr_i == DATA_ADDR);
    assign w_ld_stat = w_ld && (ex_mem_raddr_i == STAT_ADDR);
    assign w_pop     = w_ld_data && !w_empty;

    rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_flush (w_flush),
        .i_push  (w_push),
        .i_dat   (rx_data_i),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

`ifdef RECV_TIMEOUT_EN
    logic [23:0] r_idle_cnt;
    logic        r_tmo;
    logic        w_tmo_hit;
    logic        w_tmo_set;

    assign w_tmo_hit  = (r_idle_cnt == TIMEOUT_CYC);
    assign w_tmo_flag = r_tmo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_idle_cnt <= '0;
        else if (r_state != ST_RECV || rx_valid_i)
            r_idle_cnt <= '0;
        else
            r_idle_cnt <= r_idle_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_tmo <= 1'b0;
        else
            r_tmo <= (w_state_nxt == ST_ERR) && (r_tmo || w_tmo_set);
    end
`else
    assign w_tmo_flag = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_mflag_nxt = r_mflag;
        w_push      = 1'b0;
        w_flush     = 1'b0;
`ifdef RECV_TIMEOUT_EN
        w_tmo_set   = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (recv_start_i) begin
                    w_state_nxt = ST_RECV;
                    w_idx_nxt   = '0;
                    w_mflag_nxt = 1'b1;
                    w_flush     = 1'b1;
                end
            end
            ST_RECV: begin
                // Dropping the enable aborts the frame; line errors win over a same-cycle byte.
                if (!recv_start_i) begin
                    w_state_nxt = ST_IDLE;
                    w_flush     = 1'b1;
                end else if (rx_err_i) begin
                    w_state_nxt = ST_ERR;
                end else if (rx_valid_i) begin
                    if (w_full && !w_pop) begin
                        w_state_nxt = ST_ERR;
                    end else begin
                        w_push    = 1'b1;
                        w_idx_nxt = r_idx + 1'b1;
                        if (rx_data_i != exp_byte(int'(r_idx)))
                            w_mflag_nxt = 1'b0;
                        if (int'(r_idx) + 1 == ID_LEN)
                            w_state_nxt = ST_DONE;
                    end
                end
`ifdef RECV_TIMEOUT_EN
                else if (w_tmo_hit) begin
                    w_state_nxt = ST_ERR;
                    w_tmo_set   = 1'b1;
                end
`endif
            end
            default: begin
                if (!recv_start_i)
                    w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_mflag <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_match <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_mflag <= w_mflag_nxt;
            r_busy  <= (w_state_nxt == ST_RECV);
            r_done  <= (w_state_nxt == ST_DONE);
            r_match <= (w_state_nxt == ST_DONE) && w_mflag_nxt;
            r_err   <= (w_state_nxt == ST_ERR);
        end
    end

    assign busy_o  = r_busy;
    assign done_o  = r_done;
    assign match_o = r_match;
    assign err_o   = r_err;

    always_comb begin
        w_stat              = '0;
        w_stat[15:8]        = 8'(w_count);
        w_stat[STAT_TMO]    = w_tmo_flag;
        w_stat[STAT_ERR]    = r_err;
        w_stat[STAT_MATCH]  = r_match;
        w_stat[STAT_DONE]   = r_done;
        w_stat[STAT_FULL]   = w_full;
        w_stat[STAT_NEMPTY] = !w_empty;
        rdata_o = '0;
        if (w_ld_data)
            rdata_o = {24'h0, (w_empty ? 8'h00 : w_head)};
        else if (w_ld_stat)
            rdata_o = w_stat;
    end

endmodule

// File: doc/recv_id.md
Name: recv_id

Overview:
- Receive-side counterpart of the ID transmit path.
- Takes bytes from the UART RX strobe interface and buffers them in a small FIFO.
- Checks the incoming stream against the fixed 10-character student-ID string (ASCII "2023211013").
- Exposes data, status and match result to the core through load-only memory-mapped registers, decoded from the ex_to_mem bus signals.

Parameters:
- FIFO_DEPTH, 16, RX byte FIFO entries; power of 2, minimum 2.
- ID_LEN, 10, bytes in one ID frame.
- DATA_ADDR, 32'h30000010, load address that pops the FIFO head.
- STAT_ADDR, 32'h30000014, load address of the status word (no side effect).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- recv_start_i  in  1  level enable; held high for the whole reception.
- rx_valid_i  in  1  one-cycle strobe: rx_data_i holds a received byte.
- rx_data_i  in  8  received byte.
- rx_err_i  in  1  one-cycle UART frame/parity error strobe.
- ex_mem_req_i  in  1  memory access request.
- ex_mem_we_i  in  1  1 = store, 0 = load.
- ex_mem_raddr_i  in  32  load address.
- rdata_o  out  32  combinational read data for DATA_ADDR / STAT_ADDR.
- busy_o  out  1  frame reception in progress.
- done_o  out  1  ID_LEN bytes received.
- match_o  out  1  completed frame equals the expected ID.
- err_o  out  1  overflow or line error occurred.

Behaviour:
- Reset (async, rst=1): state IDLE; FIFO pointers and count = 0; byte index = 0; match flag = 1; busy_o = done_o = match_o = err_o = 0.
- rdata_o depends only on the current inputs and state.
- States: IDLE, RECV, DONE, ERR. All status outputs are registered and decoded from the state:
  - busy_o = RECV.
  - done_o = DONE.
  - err_o = ERR.
  - match_o = DONE & match flag.
- IDLE:
  - rx_valid_i is ignored.
  - recv_start_i=1 -> RECV next edge; index cleared, match flag set, FIFO flushed.
- RECV, on each rx_valid_i:
  - If FIFO not full: push rx_data_i and compare it to EXP_ID[index].
  - On mismatch, clear the match flag (sticky for the frame); index++.
  - When the push makes index == ID_LEN -> DONE.
  - rx_valid_i while FIFO full (and no pop that cycle): byte dropped -> ERR.
- rx_err_i in RECV -> ERR. If rx_err_i and rx_valid_i arrive in the same cycle, the error wins and the byte is not pushed.
- DONE/ERR: hold until recv_start_i=0, then IDLE; the FIFO keeps its contents so the core can drain it.
- recv_start_i=0 in RECV: -> IDLE next edge. Partial frame discarded, FIFO flushed, no done/err.
- Loads (ex_mem_req_i=1, ex_mem_we_i=0):
  - raddr==DATA_ADDR: rdata_o = {24'h0, FIFO head}. Head is popped at the edge if the FIFO is non-empty. When empty, returns 0 and pointers are unchanged.
  - raddr==STAT_ADDR: rdata_o = {16'h0, count[7:0], 3'b0, err, match, done, full, ~empty}.
  - Any other address or a store: rdata_o = 0, no side effect.
- Push and pop in the same cycle: both occur and count is unchanged. A full FIFO with a simultaneous pop accepts the push, so no overflow.
- Latency: a byte strobed at edge N is visible in the status word from cycle N+1; a pop updates count at the next edge.
- Pointers wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.

Optional Feature:
- Macro RECV_TIMEOUT_EN.
- Defined:
  - A 24-bit idle counter runs in RECV and clears on each rx_valid_i.
  - When it reaches TIMEOUT_CYC (package constant, 24'd1_000_000), the block -> ERR and status bit 5 = 1 (timeout).
- Undefined: no counter; RECV waits indefinitely; status bit 5 reads 0.

Decomposition:
- Shared package/defines: EXP_ID byte table (32,30,32,33,32,31,31,30,31,33 hex), state encoding, DATA_ADDR/STAT_ADDR, TIMEOUT_CYC, status bit positions.
- One sub-module: rx_fifo (synchronous FIFO: push, pop, full, empty, count, head).
- FSM, comparator and register decode stay in recv_id.

Test Plan:
- Reset mid-frame: assert rst after 4 bytes -> all outputs 0, status reads 0, a DATA_ADDR load returns 0.
- Good frame: recv_start_i=1, strobe "2023211013" -> done_o=1, match_o=1, busy_o=0; status = 0x0A0D; ten DATA_ADDR loads return 0x32..0x33 in order, then count 0.
- Bad frame: 4th byte 0x34 -> done_o=1, match_o=0; status bit2=1, bit3=0.
- Overflow: FIFO_DEPTH=4, ID_LEN=10, 5 strobes with no loads -> ERR after 5th, err_o=1, count=4. Repeat with a pop in the same cycle as the 5th strobe -> no error.
- rx_err_i together with rx_valid_i on byte 3 -> err_o=1, count=2; drop recv_start_i -> IDLE, err_o=0 next cycle.
- RECV_TIMEOUT_EN with TIMEOUT_CYC=100: 3 bytes then idle -> err_o=1 and status bit5=1 at 100 idle cycles.
